// File: rtl/dram_rd_trainer.sv
// dram_rd_trainer: read-eye training for W DQ byte lanes. Sweeps the IDELAY
// tap, issues a training read per tap, then loads each lane's window centre.
// Ports: dclk, reset (sync, active-high), start, idelayctl_rdy, rd_req,
//   rd_valid, rd_data[W*64], ld[W], cntvaluein[W*5], busy, done, err,
//   lane_fail[W]; pass_map[W*TAPS] when DRAM_TRAIN_PASSMAP_EN is defined.
module dram_rd_trainer #(
  parameter int          W       = 8,
  parameter int          TAPS    = 32,
  parameter int          SETTLE  = 8,
  parameter int          TIMEOUT = 255,
  parameter logic [63:0] EXP_PAT = 64'h00FF_00FF_55AA_55AA
) (
  input  logic              dclk,
  input  logic              reset,
  input  logic              start,
  input  logic              idelayctl_rdy,
  output logic              rd_req,
  input  logic              rd_valid,
  input  logic [W*64-1:0]   rd_data,
  output logic [W-1:0]      ld,
  output logic [W*5-1:0]    cntvaluein,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef DRAM_TRAIN_PASSMAP_EN
  output logic [W*TAPS-1:0] pass_map,
`endif
  output logic [W-1:0]      lane_fail
);

  localparam int LW   = $clog2(TAPS) + 1;
  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_READ,
    S_CHECK, S_FINAL, S_DONE, S_ERROR
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    tap_q, tap_d;
  logic          start_ok;

  logic [W-1:0][4:0]    cval_q, cval_d;
  logic [W-1:0][4:0]    cur_start_q, best_start_q;
  logic [W-1:0][LW-1:0] cur_len_q, best_len_q;
  logic [W-1:0]         pass_q, hit, lane_fail_q;

  logic [W-1:0][4:0]    ns_d, bs_d, cen;
  logic [W-1:0][LW-1:0] nl_d, bl_d;

  always_comb begin
    for (int i = 0; i < W; i++) begin
      hit[i] = (rd_data[64*i +: 64] == EXP_PAT);
    end
  end

  // Run-length window tracking; strict > keeps the earliest of equal windows.
  always_comb begin
    ns_d = cur_start_q;
    nl_d = cur_len_q;
    bs_d = best_start_q;
    bl_d = best_len_q;
    for (int i = 0; i < W; i++) begin
      if (pass_q[i]) begin
        ns_d[i] = (cur_len_q[i] == '0) ? tap_q : cur_start_q[i];
        nl_d[i] = cur_len_q[i] + LW'(1);
        if (nl_d[i] > best_len_q[i]) begin
          bs_d[i] = ns_d[i];
          bl_d[i] = nl_d[i];
        end
      end else begin
        nl_d[i] = '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      if (best_len_q[i] == '0) begin
        cen[i] = 5'd0;
      end else begin
        cen[i] = best_start_q[i] + 5'(best_len_q[i] >> 1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tap_d    = tap_q;
    cval_d   = cval_q;
    start_ok = 1'b0;
    rd_req   = 1'b0;
    ld       = '0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          start_ok = 1'b1;
          tap_d    = '0;
          state_d  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (idelayctl_rdy) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld = '1;
        for (int i = 0; i < W; i++) cval_d[i] = tap_q;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        rd_req = (cnt_q == '0);
        if (rd_valid) begin
          state_d = S_CHECK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (tap_q == 5'(TAPS - 1)) begin
          state_d = S_FINAL;
        end else begin
          tap_d   = tap_q + 5'd1;
          state_d = S_LOAD;
        end
      end
      S_FINAL: begin
        ld      = '1;
        cval_d  = cen;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tap value is presented in the same cycle as its load strobe.
  assign cntvaluein = cval_d;
  assign busy = (state_q != S_IDLE) && (state_q != S_DONE) &&
                (state_q != S_ERROR);
  assign done = (state_q == S_DONE);
  assign err  = (state_q == S_ERROR);
  assign lane_fail = lane_fail_q;

  always_ff @(posedge dclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tap_q   <= '0;
      cval_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      cval_q  <= cval_d;
    end
  end

  always_ff @(posedge dclk) begin
    if (reset) begin
      pass_q       <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      lane_fail_q  <= '0;
    end else begin
      if (start_ok) begin
        cur_start_q  <= '0;
        cur_len_q    <= '0;
        best_start_q <= '0;
        best_len_q   <= '0;
        lane_fail_q  <= '0;
      end
      if (state_q == S_READ && rd_valid) pass_q <= hit;
      if (state_q == S_CHECK) begin
        cur_start_q  <= ns_d;
        cur_len_q    <= nl_d;
        best_start_q <= bs_d;
        best_len_q   <= bl_d;
      end
      if (state_q == S_FINAL) begin
        for (int i = 0; i < W; i++) begin
          lane_fail_q[i] <= (best_len_q[i] == '0);
        end
      end
    end
  end

`ifdef DRAM_TRAIN_PASSMAP_EN
  logic [W*TAPS-1:0] pass_map_q;

  always_ff @(posedge dclk) begin
    if (reset || start_ok) begin
      pass_map_q <= '0;
    end else if (state_q == S_CHECK) begin
      for (int i = 0; i < W; i++) begin
        pass_map_q[i*TAPS + int'(tap_q)] <= pass_q[i];
      end
    end
  end

  assign pass_map = pass_map_q;
`endif

endmodule
